// File: rtl/nmea_checksum_checker.sv
// Frames NMEA sentences ('$' body '*hh' CR LF), XORs the body and checks it against the hex digits.
// Verdict pulses one cycle after the deciding byte; no backpressure, a byte may arrive every cycle.
module nmea_checksum_checker #(
  parameter int MAX_LEN  = 82,
  parameter int CNT_BITS = 8
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                in_sentence,
  output logic [7:0]          calc_sum,
  output logic                sentence_done,
  output logic                sentence_ok,
  output logic [1:0]          err_code,
  output logic [CNT_BITS-1:0] good_count,
  output logic [CNT_BITS-1:0] bad_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BODY     = 3'd1;
  localparam logic [2:0] S_HEX_HI   = 3'd2;
  localparam logic [2:0] S_HEX_LO   = 3'd3;
  localparam logic [2:0] S_WAIT_EOL = 3'd4;

  localparam int LEN_BITS = $clog2(MAX_LEN + 2);
  localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
  localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(MAX_LEN);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SUM    = 2'd1;
  localparam logic [1:0] ERR_FORMAT = 2'd2;
  localparam logic [1:0] ERR_OVFL   = 2'd3;

  logic [2:0]          state;
  logic [2:0]          nxt_state;
  logic [LEN_BITS-1:0] len;
  logic [7:0]          rx_sum;
  logic                is_hex;
  logic [3:0]          nib;
  logic                pass;
  logic                fail;
  logic [1:0]          fail_code;

  logic is_dollar, is_star, is_cr, is_lf, len_full;
  assign is_dollar = (rx_data == 8'h24);
  assign is_star   = (rx_data == 8'h2A);
  assign is_cr     = (rx_data == 8'h0D);
  assign is_lf     = (rx_data == 8'h0A);
  // The incoming byte would push the sentence past MAX_LEN.
  assign len_full  = (len >= LEN_MAX);

  // Letters map via low nibble + 9 ('A'/'a' -> 1 + 9 = 10).
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      nib = rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  always_comb begin
    nxt_state = state;
    pass      = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (rx_valid) begin
      if (state != S_IDLE && len_full) begin
        fail      = 1'b1;
        fail_code = ERR_OVFL;
        nxt_state = S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (is_dollar) nxt_state = S_BODY;
          end
          S_BODY: begin
            if (is_dollar) begin
              fail      = 1'b1;
              fail_code = ERR_OVFL;
            end else if (is_star) begin
              nxt_state = S_HEX_HI;
            end else if (is_cr || is_lf) begin
              fail      = 1'b1;
              fail_code = ERR_FORMAT;
              nxt_state = S_IDLE;
            end
          end
          S_HEX_HI, S_HEX_LO: begin
            if (is_hex) begin
              nxt_state = (state == S_HEX_HI) ? S_HEX_LO : S_WAIT_EOL;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_FORMAT;
              nxt_state = S_IDLE;
            end
          end
          S_WAIT_EOL: begin
            if (is_lf) begin
              nxt_state = S_IDLE;
              if (rx_sum == calc_sum) begin
                pass = 1'b1;
              end else begin
                fail      = 1'b1;
                fail_code = ERR_SUM;
              end
            end else if (!is_cr) begin
              fail      = 1'b1;
              fail_code = ERR_FORMAT;
              nxt_state = S_IDLE;
            end
          end
          default: nxt_state = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      len           <= '0;
      rx_sum        <= '0;
      in_sentence   <= 1'b0;
      calc_sum      <= '0;
      sentence_done <= 1'b0;
      sentence_ok   <= 1'b0;
      err_code      <= ERR_NONE;
      good_count    <= '0;
      bad_count     <= '0;
    end else begin
      state         <= nxt_state;
      in_sentence   <= (nxt_state != S_IDLE);
      sentence_done <= pass | fail;
      sentence_ok   <= pass;
      if (pass) err_code <= ERR_NONE;
      else if (fail) err_code <= fail_code;
      if (pass && good_count != '1) good_count <= good_count + CNT_ONE;
      if (fail && bad_count != '1) bad_count <= bad_count + CNT_ONE;

      if (rx_valid) begin
        if (state == S_IDLE) begin
          if (is_dollar) begin
            calc_sum <= '0;
            len      <= LEN_ONE;
          end
        end else if (!len_full) begin
          len <= len + LEN_ONE;
          case (state)
            S_BODY: begin
              // A stray '$' restarts the sentence in place.
              if (is_dollar) begin
                calc_sum <= '0;
                len      <= LEN_ONE;
              end else if (!is_star && !is_cr && !is_lf) begin
                calc_sum <= calc_sum ^ rx_data;
              end
            end
            S_HEX_HI: if (is_hex) rx_sum[7:4] <= nib;
            S_HEX_LO: if (is_hex) rx_sum[3:0] <= nib;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_checksum_checker.sv
// Bench for nmea_checksum_checker: directed sentences plus random traffic against a sentence-buffer model.
module tb_nmea_checksum_checker;
  localparam int MAX_LEN = 82;
  localparam logic [7:0] DOL = 8'h24, STAR = 8'h2A, CR = 8'h0D, LF = 8'h0A;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       in_sentence, sentence_done, sentence_ok;
  logic [7:0] calc_sum, good_count, bad_count;
  logic [1:0] err_code;
  logic       s_in_sentence, s_done, s_ok;
  logic [7:0] s_calc_sum;
  logic [1:0] s_err_code, s_good, s_bad;

  nmea_checksum_checker #(.MAX_LEN(MAX_LEN), .CNT_BITS(8)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .in_sentence(in_sentence), .calc_sum(calc_sum), .sentence_done(sentence_done),
    .sentence_ok(sentence_ok), .err_code(err_code), .good_count(good_count), .bad_count(bad_count));

  nmea_checksum_checker #(.MAX_LEN(MAX_LEN), .CNT_BITS(2)) dut_small (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .in_sentence(s_in_sentence), .calc_sum(s_calc_sum), .sentence_done(s_done),
    .sentence_ok(s_ok), .err_code(s_err_code), .good_count(s_good), .bad_count(s_bad));

  always #10 clk_50MHz = ~clk_50MHz;

  int checks = 0;
  int errors = 0;

  // Model: the bytes of the current sentence and the last verdict.
  logic [7:0] q[$];
  bit         m_in, m_done, m_ok;
  logic [7:0] m_sum;
  logic [1:0] m_err;
  int         m_good, m_bad;

  int n_done = 0;
  bit last_ok;
  logic [1:0] last_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hexdig(logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hexval(logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  function automatic int star_idx();
    for (int i = 0; i < q.size(); i++) if (q[i] == STAR) return i;
    return -1;
  endfunction

  function automatic logic [7:0] body_xor();
    logic [7:0] x = 8'h00;
    for (int i = 1; i < q.size(); i++) x ^= q[i];
    return x;
  endfunction

  function automatic int sat(int v, int bits);
    return (v > (1 << bits) - 1) ? (1 << bits) - 1 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_in = 0; m_done = 0; m_ok = 0; m_sum = 8'h00; m_err = 2'd0; m_good = 0; m_bad = 0;
  endtask

  task automatic verdict(bit ok, logic [1:0] code);
    m_done = 1; m_ok = ok; m_err = code;
    if (ok) m_good++; else m_bad++;
  endtask

  task automatic model_step(bit v, logic [7:0] b);
    int st;
    int rx;
    m_done = 0; m_ok = 0;
    if (!v) return;
    if (!m_in) begin
      if (b == DOL) begin q = {b}; m_in = 1; m_sum = 8'h00; end
      return;
    end
    if (q.size() >= MAX_LEN) begin verdict(0, 2'd3); m_in = 0; return; end
    st = star_idx();
    if (st < 0) begin
      if (b == DOL) begin verdict(0, 2'd3); q = {b}; m_sum = 8'h00; end
      else if (b == STAR) q.push_back(b);
      else if (b == CR || b == LF) begin verdict(0, 2'd2); m_in = 0; end
      else begin q.push_back(b); m_sum = body_xor(); end
    end else if (q.size() - st - 1 < 2) begin
      if (hexdig(b)) q.push_back(b);
      else begin verdict(0, 2'd2); m_in = 0; end
    end else if (b == CR) begin
      q.push_back(b);
    end else if (b == LF) begin
      rx = hexval(q[st+1]) * 16 + hexval(q[st+2]);
      verdict(rx == int'(m_sum), (rx == int'(m_sum)) ? 2'd0 : 2'd1);
      m_in = 0;
    end else begin
      verdict(0, 2'd2); m_in = 0;
    end
  endtask

  // Single compare process: outputs after each edge against the model.
  always @(posedge clk_50MHz) begin
    #1;
    chk("in_sentence", 32'(in_sentence), 32'(m_in));
    chk("calc_sum", 32'(calc_sum), 32'(m_sum));
    chk("sentence_done", 32'(sentence_done), 32'(m_done));
    chk("sentence_ok", 32'(sentence_ok), 32'(m_ok));
    if (m_done) chk("err_code", 32'(err_code), 32'(m_err));
    chk("good_count", 32'(good_count), 32'(sat(m_good, 8)));
    chk("bad_count", 32'(bad_count), 32'(sat(m_bad, 8)));
    chk("small_good", 32'(s_good), 32'(sat(m_good, 2)));
    chk("small_bad", 32'(s_bad), 32'(sat(m_bad, 2)));
    if (sentence_done) begin
      n_done++; last_ok = sentence_ok; last_err = err_code;
    end
  end

  task automatic cyc(bit v, logic [7:0] b);
    @(negedge clk_50MHz);
    rx_valid = v;
    rx_data  = b;
    model_step(v, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 8'($urandom));
  endtask

  task automatic send_str(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1, s[i]);
      idle(gap);
    end
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk_50MHz);
    reset = 1; rx_valid = 0;
    model_reset();
    @(negedge clk_50MHz);
    reset = 0;
  endtask

  function automatic logic [7:0] hexc(logic [3:0] n, bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h57 : 8'h37) + 8'(n);
  endfunction

  int n0;
  logic [7:0] s[$];
  logic [7:0] x;
  int c, kind, blen, gap;
  bit lc;

  initial begin
    model_reset();
    idle(2);
    reset = 0;
    idle(1);
    chk("rst_sum", 32'(calc_sum), 32'h0);
    chk("rst_good", 32'(good_count), 32'h0);
    chk("rst_err", 32'(err_code), 32'h0);

    n0 = n_done;
    send_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n", 5);
    chk("gpgga_ndone", 32'(n_done - n0), 32'd1);
    chk("gpgga_ok", 32'(last_ok), 32'd1);
    chk("gpgga_sum", 32'(calc_sum), 32'h47);
    chk("gpgga_err", 32'(last_err), 32'd0);
    chk("gpgga_good", 32'(good_count), 32'd1);

    send_str("$AB*03\r\n", 0);
    chk("ab03_ok", 32'(last_ok), 32'd1);
    send_str("$AB*04\r\n", 0);
    chk("ab04_err", 32'(last_err), 32'd1);
    chk("ab04_bad", 32'(bad_count), 32'd1);
    chk("ab04_sum", 32'(calc_sum), 32'h03);

    n0 = n_done;
    send_str("$A*4g\r\n", 1);
    chk("badhex_ndone", 32'(n_done - n0), 32'd1);
    chk("badhex_err", 32'(last_err), 32'd2);
    n0 = n_done;
    send_str("$ABC\r\n", 0);
    chk("nostar_ndone", 32'(n_done - n0), 32'd1);
    chk("nostar_err", 32'(last_err), 32'd2);
    chk("nostar_bad", 32'(bad_count), 32'd3);

    n0 = n_done;
    send_str("$GP$A*41\n", 0);
    chk("resync_ndone", 32'(n_done - n0), 32'd2);
    chk("resync_ok", 32'(last_ok), 32'd1);
    chk("resync_sum", 32'(calc_sum), 32'h41);
    chk("resync_good", 32'(good_count), 32'd3);
    chk("resync_bad", 32'(bad_count), 32'd4);

    n0 = n_done;
    cyc(1, DOL);
    for (int i = 0; i < 81; i++) cyc(1, 8'h42);
    idle(2);
    chk("len82_ndone", 32'(n_done - n0), 32'd0);
    chk("len82_insent", 32'(in_sentence), 32'd1);
    cyc(1, 8'h42);
    idle(2);
    chk("len83_ndone", 32'(n_done - n0), 32'd1);
    chk("len83_err", 32'(last_err), 32'd3);
    chk("len83_insent", 32'(in_sentence), 32'd0);
    send_str("BBBBBBBB\r\n", 0);
    send_str("$A*41\n", 0);
    chk("after_ovfl_ok", 32'(last_ok), 32'd1);

    send_str("$GPRMC,12", 0);
    n0 = n_done;
    do_reset();
    send_str("$A*41\n", 0);
    chk("postrst_ndone", 32'(n_done - n0), 32'd1);
    chk("postrst_ok", 32'(last_ok), 32'd1);
    chk("postrst_good", 32'(good_count), 32'd1);
    chk("postrst_bad", 32'(bad_count), 32'd0);
    for (int i = 0; i < 4; i++) send_str("$A*41\r\n", 0);
    chk("sat_good5", 32'(good_count), 32'd5);
    chk("sat_small", 32'(s_good), 32'd3);

    for (int k = 0; k < 250; k++) begin
      kind = $urandom_range(0, 9);
      lc   = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      blen = (kind == 3) ? $urandom_range(75, 85) : $urandom_range(1, 20);
      s = {DOL};
      x = 8'h00;
      for (int i = 0; i < blen; i++) begin
        do c = $urandom_range(32, 126); while (c == 36 || c == 42);
        s.push_back(8'(c));
        x ^= 8'(c);
      end
      if (kind == 0) x ^= 8'($urandom_range(1, 255));
      s.push_back(STAR);
      s.push_back(hexc(x[7:4], lc));
      s.push_back(hexc(x[3:0], lc));
      if ($urandom_range(0, 1) == 1) s.push_back(CR);
      s.push_back(LF);
      if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: s[$urandom_range(1, s.size() - 1)] = DOL;
          1: s[$urandom_range(1, s.size() - 1)] = STAR;
          2: s[$urandom_range(1, s.size() - 1)] = CR;
          3: s[$urandom_range(1, s.size() - 1)] = LF;
          default: s[$urandom_range(1, s.size() - 1)] = 8'h67;
        endcase
      end
      if (kind == 2) for (int i = 0; i < 3; i++) cyc(1, 8'($urandom_range(32, 126)));
      foreach (s[i]) begin
        cyc(1, s[i]);
        idle(gap);
      end
      idle($urandom_range(0, 3));
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
